axi4_stream_arb: RTL and testbench

Packet-aware round-robin arbiter that shares one AXI4-Stream output between SN input streams. It grants one input at a time and holds the grant for a whole packet, up to and including the TLAST beat. It then rotates priority to the next enabled requester. It sits in front of shared stream consumers (DMA writers, acquisition buffers) that previously saw a statically selected input.

---
 rtl/axi4_stream_if.sv | 17 +
 rtl/axi4_stream_arb.sv | 136 +++++++++++++
 tb/tb_axi4_stream_arb.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle. The d modport is the receiving side (sees TVALID, drives TREADY);
// the s modport is the sending side.
interface axi4_stream_if #(
  parameter int unsigned DN = 1,
  parameter type         DT = logic [7:0]
) ();

  DT    [DN-1:0] TDATA;
  logic [DN-1:0] TKEEP;
  logic          TLAST;
  logic          TVALID;
  logic          TREADY;

  modport d (input TDATA, input TKEEP, input TLAST, input TVALID, output TREADY);
  modport s (output TDATA, output TKEEP, output TLAST, output TVALID, input TREADY);

endinterface

// File: rtl/axi4_stream_arb.sv
// Packet-aware round-robin arbiter: one AXI4-Stream output shared by SN inputs,
// grant held from first beat through the TLAST handshake, then priority rotates.
module axi4_stream_arb #(
  parameter int unsigned SN = 2,
  parameter int unsigned SW = (SN > 1) ? $clog2(SN) : 1,
  parameter int unsigned DN = 1,
  parameter type         DT = logic [7:0]
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic [SN-1:0] ena,
  axi4_stream_if.d      sti [SN-1:0],
  axi4_stream_if.s      sto,
  output logic [SW-1:0] sel,
  output logic          busy,
  output logic [31:0]   pkt_cnt
);

  localparam logic [0:0]  StIdle = 1'b0;
  localparam logic [0:0]  StPkt  = 1'b1;
  localparam logic [SW:0] SnW    = (SW+1)'(SN);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [31:0]   cnt_q, cnt_d;

  logic [SN-1:0] tvalid, tlast, tready, req;
  DT    [DN-1:0] tdata [SN];
  logic [DN-1:0] tkeep [SN];

  logic          o_valid, o_last;
  DT    [DN-1:0] o_data;
  logic [DN-1:0] o_keep;

  logic          last_hs, any_req;
  logic [SW-1:0] sel_inc, ptr_eff, off, win;
  logic [2*SN-1:0] req2;
  logic [SN-1:0] req_rot;
  logic [SW:0]   win_sum;

  // Interface arrays only accept constant indices, so flatten them here.
  for (genvar g = 0; g < SN; g++) begin : g_in
    assign tvalid[g]     = sti[g].TVALID;
    assign tlast[g]      = sti[g].TLAST;
    assign tdata[g]      = sti[g].TDATA;
    assign tkeep[g]      = sti[g].TKEEP;
    assign sti[g].TREADY = tready[g];
  end

  assign req = tvalid & ena;

  always_comb begin
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_data  = '0;
    o_keep  = '0;
    tready  = '0;
    if (state_q == StPkt) begin
      for (int i = 0; i < SN; i++) begin
        if (sel_q == SW'(i)) begin
          o_valid   = tvalid[i];
          o_last    = tlast[i];
          o_data    = tdata[i];
          o_keep    = tkeep[i];
          tready[i] = sto.TREADY;
        end
      end
    end
  end

  assign sto.TVALID = o_valid;
  assign sto.TLAST  = o_last;
  assign sto.TDATA  = o_data;
  assign sto.TKEEP  = o_keep;

  assign last_hs = (state_q == StPkt) & o_valid & sto.TREADY & o_last;
  assign sel_inc = (sel_q == SW'(SN - 1)) ? '0 : sel_q + 1'b1;

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  always_comb begin
    ptr_eff = last_hs ? sel_inc : ptr_q;
    any_req = |req;
    req2    = {req, req};
    req_rot = SN'(req2 >> ptr_eff);
    off     = '0;
    for (int k = SN - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off = SW'(k);
      end
    end
    win_sum = {1'b0, ptr_eff} + {1'b0, off};
    if (win_sum >= SnW) begin
      win_sum = win_sum - SnW;
    end
    win = win_sum[SW-1:0];
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (last_hs) begin
      ptr_d = sel_inc;
      cnt_d = cnt_q + 32'd1;
    end
    if ((state_q == StIdle) || last_hs) begin
      if (any_req) begin
        state_d = StPkt;
        sel_d   = win;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel     = sel_q;
  assign busy    = (state_q == StPkt);
  assign pkt_cnt = cnt_q;

endmodule

// File: tb/tb_axi4_stream_arb.sv
// Bench for axi4_stream_arb with SN=3: a fixed vector table for lock/wrap corners,
// then randomized traffic checked against a packet-level arbitration model.
module tb_axi4_stream_arb;

  localparam int unsigned SN = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned DN = 1;
  typedef logic [7:0] dt_t;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [SN-1:0] ena, tv, tl, kp, trdy;
  logic [7:0]    td [SN];
  logic          o_rdy, o_val, o_last, o_keep;
  logic [7:0]    o_data;
  logic [SW-1:0] sel;
  logic          busy;
  logic [31:0]   pkt_cnt;

  axi4_stream_if #(.DN(DN), .DT(dt_t)) sti [SN-1:0] ();
  axi4_stream_if #(.DN(DN), .DT(dt_t)) sto ();

  for (genvar g = 0; g < SN; g++) begin : g_src
    assign sti[g].TVALID = tv[g];
    assign sti[g].TLAST  = tl[g];
    assign sti[g].TDATA  = td[g];
    assign sti[g].TKEEP  = kp[g];
    assign trdy[g]       = sti[g].TREADY;
  end

  assign sto.TREADY = o_rdy;
  assign o_val      = sto.TVALID;
  assign o_last     = sto.TLAST;
  assign o_data     = sto.TDATA;
  assign o_keep     = sto.TKEEP;

  axi4_stream_arb #(.SN(SN), .SW(SW), .DN(DN), .DT(dt_t)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .ena     (ena),
    .sti     (sti),
    .sto     (sto),
    .sel     (sel),
    .busy    (busy),
    .pkt_cnt (pkt_cnt)
  );

  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  // Model and source state
  bit          m_busy;
  int          m_sel, m_ptr;
  logic [31:0] m_cnt;
  int          s_beat [SN];
  int          s_len  [SN];
  int          s_seq  [SN];
  int          pend;
  bit          cont;
  int          cont_len;

  typedef struct {
    logic [2:0]  ena, tv, tl;
    logic        rdy;
    logic        busy;
    logic [1:0]  sel;
    logic        ov, ol;
    logic [2:0]  tr;
    logic [31:0] cnt;
  } vec_t;
  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_busy, input logic [1:0] e_sel,
                               input logic e_val, input logic e_last, input logic [7:0] e_data,
                               input logic e_keep, input logic [2:0] e_tr, input logic [31:0] e_cnt);
    check({tag, "_busy"}, 32'(busy), 32'(e_busy));
    if (e_busy) check({tag, "_sel"}, 32'(sel), 32'(e_sel));
    check({tag, "_tvalid"}, 32'(o_val), 32'(e_val));
    check({tag, "_tlast"}, 32'(o_last), 32'(e_last));
    check({tag, "_tdata"}, 32'(o_data), 32'(e_data));
    check({tag, "_tkeep"}, 32'(o_keep), 32'(e_keep));
    check({tag, "_tready"}, 32'(trdy), 32'(e_tr));
    check({tag, "_pkt_cnt"}, pkt_cnt, e_cnt);
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    m_cnt  = '0;
    pend   = -1;
    for (int i = 0; i < SN; i++) begin
      s_beat[i] = 0;
      s_seq[i]  = 0;
      s_len[i]  = cont ? cont_len : int'($urandom_range(5, 1));
    end
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    tv      = '0;
    tl      = '0;
    kp      = '0;
    ena     = '1;
    o_rdy   = 1'b1;
    model_reset();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  // One clock: drive sources at negedge, compare against the model, advance the model.
  task automatic cycle(input string tag);
    logic [SN-1:0] req, e_tr;
    bit hs, last;
    @(negedge ACLK);
    if (pend >= 0) begin
      s_seq[pend]++;
      if (s_beat[pend] == s_len[pend] - 1) begin
        s_beat[pend] = 0;
        s_len[pend]  = cont ? cont_len : int'($urandom_range(5, 1));
      end else begin
        s_beat[pend]++;
      end
      tv[pend] = 1'b0;
      pend     = -1;
    end
    for (int i = 0; i < SN; i++) begin
      if (!tv[i] && (cont || $urandom_range(2, 0) != 0)) tv[i] = 1'b1;
      td[i] = 8'((i << 6) | (s_seq[i] & 63));
      kp[i] = s_seq[i][0];
      tl[i] = (s_beat[i] == s_len[i] - 1);
    end
    if (!cont) begin
      o_rdy = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) ena[$urandom_range(SN - 1, 0)] ^= 1'b1;
    end
    #1;
    e_tr = '0;
    if (m_busy && o_rdy) e_tr[m_sel] = 1'b1;
    check_outputs(tag, m_busy, 2'(m_sel), m_busy && tv[m_sel], m_busy && tl[m_sel],
                  m_busy ? td[m_sel] : 8'h00, m_busy && kp[m_sel], e_tr, m_cnt);
    req  = tv & ena;
    hs   = m_busy && tv[m_sel] && o_rdy;
    last = hs && tl[m_sel];
    if (hs) pend = m_sel;
    if (last) begin
      m_cnt++;
      m_ptr = (m_sel + 1) % SN;
    end
    if (!m_busy || last) begin
      m_busy = 1'b0;
      for (int k = 0; k < SN; k++) begin
        if (!m_busy && req[(m_ptr + k) % SN]) begin
          m_busy = 1'b1;
          m_sel  = (m_ptr + k) % SN;
        end
      end
    end
  endtask

  initial begin
    // ena tv tl rdy | busy sel ov ol tr cnt
    vecs[0]  = '{3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 32'd0};
    vecs[1]  = '{3'b111, 3'b010, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 32'd0};
    vecs[2]  = '{3'b111, 3'b011, 3'b000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010, 32'd0};
    vecs[3]  = '{3'b101, 3'b011, 3'b000, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 3'b010, 32'd0};
    vecs[4]  = '{3'b101, 3'b011, 3'b010, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 3'b000, 32'd0};
    vecs[5]  = '{3'b101, 3'b011, 3'b010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 3'b010, 32'd0};
    vecs[6]  = '{3'b101, 3'b011, 3'b001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 3'b001, 32'd1};
    vecs[7]  = '{3'b101, 3'b010, 3'b000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3'b001, 32'd2};
    vecs[8]  = '{3'b111, 3'b101, 3'b001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 3'b001, 32'd2};
    vecs[9]  = '{3'b111, 3'b101, 3'b100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 3'b100, 32'd3};
    vecs[10] = '{3'b111, 3'b000, 3'b000, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3'b001, 32'd4};
    vecs[11] = '{3'b110, 3'b001, 3'b001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 3'b001, 32'd4};
    vecs[12] = '{3'b111, 3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 32'd5};

    cont     = 1'b0;
    cont_len = 3;
    for (int i = 0; i < SN; i++) td[i] = 8'h11 * 8'(i + 1);

    // Reset with every input valid, then first grant to input 0 one cycle after release.
    ARESETn = 1'b0;
    ena     = '1;
    tv      = '1;
    tl      = '0;
    kp      = '1;
    o_rdy   = 1'b1;
    @(negedge ACLK);
    #1;
    check_outputs("reset", 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    ARESETn = 1'b1;
    #1;
    check_outputs("release", 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 32'd0);
    @(negedge ACLK);
    #1;
    check_outputs("first_grant", 1'b1, 2'd0, 1'b1, 1'b0, 8'h11, 1'b1, 3'b001, 32'd0);

    // Table: packet lock, backpressured TLAST, ena masking, wrap from 2 to 0, idle return.
    ARESETn = 1'b0;
    tv      = '0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int v = 0; v < 13; v++) begin
      @(negedge ACLK);
      ena   = vecs[v].ena;
      tv    = vecs[v].tv;
      tl    = vecs[v].tl;
      o_rdy = vecs[v].rdy;
      #1;
      check_outputs($sformatf("vec%0d", v), vecs[v].busy, vecs[v].sel, vecs[v].ov, vecs[v].ol,
                    vecs[v].busy ? 8'h11 * 8'(vecs[v].sel + 1) : 8'h00, vecs[v].busy,
                    vecs[v].tr, vecs[v].cnt);
    end

    // Continuous 3-beat packets on all inputs: strict rotation with no bubbles.
    cont     = 1'b1;
    cont_len = 3;
    do_reset();
    cycle("rr");
    for (int c = 1; c <= 24; c++) begin
      cycle("rr");
      check("rr_order", 32'(sel), 32'(((c - 1) / 3) % SN));
      check("rr_no_bubble", 32'(o_val), 32'd1);
    end
    cycle("rr");
    check("rr_pkt_cnt_24_beats", pkt_cnt, 32'd8);

    // Randomized traffic, backpressure and enable toggling.
    cont = 1'b0;
    do_reset();
    repeat (600) cycle("rnd");

    // Reset on beat 2 of a 4-beat packet.
    cont     = 1'b1;
    cont_len = 4;
    do_reset();
    repeat (3) cycle("rmp");
    check("rmp_busy_before", 32'(busy), 32'd1);
    ARESETn = 1'b0;
    #1;
    check_outputs("rmp_reset", 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'b000, 32'd0);
    check("rmp_sel", 32'(sel), 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
